// File: rtl/jtag_tap.sv
// rtl/jtag_tap.sv - IEEE 1149.1-style TAP controller with IR, BYPASS, IDCODE and USER data registers.
module jtag_tap #(
  parameter int                    IR_WIDTH      = 4,
  parameter logic [31:0]           IDCODE_VALUE  = 32'h000FAF01,
  parameter int                    USER_DR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0]   INSTR_IDCODE  = IR_WIDTH'(4'b1110),
  parameter logic [IR_WIDTH-1:0]   INSTR_USER    = IR_WIDTH'(4'b1010)
) (
  input  logic                     tck,
  input  logic                     trst_n,
  input  logic                     tms,
  input  logic                     tdi,
  input  logic                     enable,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [IR_WIDTH-1:0]      ir_value,
  output logic [3:0]               tap_state,
  input  logic [USER_DR_WIDTH-1:0] user_capture,
  output logic [USER_DR_WIDTH-1:0] user_dr,
  output logic                     user_update
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  tap_state_t state, next_state;

  logic [IR_WIDTH-1:0]      ir_shift;
  logic [31:0]              idcode_shift;
  logic [USER_DR_WIDTH-1:0] user_shift;
  logic                     bypass_reg;
  logic                     sel_idcode;
  logic                     sel_user;
  logic                     dr_lsb;

  assign tap_state = state;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)
      state <= TLR;
    else if (!enable)
      state <= TLR;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR: next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR: next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // Anything that is neither IDCODE nor USER (including all-ones) falls through to BYPASS.
  assign sel_idcode = (ir_value == INSTR_IDCODE);
  assign sel_user   = !sel_idcode && (ir_value == INSTR_USER);
  assign dr_lsb     = sel_idcode ? idcode_shift[0] :
                      sel_user   ? user_shift[0]   : bypass_reg;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_value     <= INSTR_IDCODE;
      ir_shift     <= '0;
      idcode_shift <= '0;
      user_shift   <= '0;
      bypass_reg   <= 1'b0;
      user_dr      <= '0;
      user_update  <= 1'b0;
      tdo          <= 1'b0;
      tdo_en       <= 1'b0;
    end else if (!enable) begin
      ir_value    <= INSTR_IDCODE;
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      user_update <= 1'b0;
    end else begin
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      user_update <= 1'b0;

      // Loading on entry as well guarantees IDCODE is selected whenever TLR is reached.
      if (state == TLR || next_state == TLR)
        ir_value <= INSTR_IDCODE;
      else if (state == UPD_IR)
        ir_value <= ir_shift;

      case (state)
        CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
        SH_IR: begin
          tdo      <= ir_shift[0];
          tdo_en   <= 1'b1;
          ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        end
        CAP_DR: begin
          if (sel_idcode)
            idcode_shift <= IDCODE_VALUE;
          else if (sel_user)
            user_shift <= user_capture;
          else
            bypass_reg <= 1'b0;
        end
        SH_DR: begin
          tdo    <= dr_lsb;
          tdo_en <= 1'b1;
          if (sel_idcode)
            idcode_shift <= {tdi, idcode_shift[31:1]};
          else if (sel_user)
            user_shift <= (user_shift >> 1) |
                          (USER_DR_WIDTH'(tdi) << (USER_DR_WIDTH - 1));
          else
            bypass_reg <= tdi;
        end
        UPD_DR: begin
          if (sel_user) begin
            user_dr     <= user_shift;
            user_update <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
